fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction injected into decode.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port StallF, input, 1, hold PCF.
REQ-006 SHALL have port StallD, input, 1, hold the IF/ID register.
REQ-007 SHALL have port FlushD, input, 1, replace the IF/ID contents with a bubble.
REQ-008 SHALL have port PCSrcE, input, 1, redirect request from execute (taken branch/jump).
REQ-009 SHALL have port PCTargetE, input, 32, redirect target address.
REQ-010 SHALL have port InstrF, input, 32, instruction read from instruction memory at PCF (combinational, same cycle).
REQ-011 SHALL have port PCF, output, 32, current fetch address to instruction memory.
REQ-012 SHALL have port InstrD, output, 32, registered instruction presented to decode and the immediate extender.
REQ-013 SHALL have port PCD, output, 32, registered PC of InstrD.
REQ-014 SHALL have port PCPlus4D, output, 32, registered PCD+4.
REQ-015 SHALL have port ValidD, output, 1, InstrD is a real fetched instruction (0 = bubble).

Function
REQ-016 SHALL compute PCPlus4F = PCF + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-017 SHALL compute next PC = PCSrcE ? {PCTargetE[31:2],2'b00} : PCPlus4F; target low two bits always cleared.
REQ-018 SHALL load next PC into PCF each cycle when StallF=0 or PCSrcE=1; otherwise hold PCF.
REQ-019 SHALL give PCSrcE priority over StallF (redirect always taken in the cycle asserted).
REQ-020 SHALL, when FlushD=1, load InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, regardless of StallD.
REQ-021 SHALL, when FlushD=0 and StallD=0, load InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
REQ-022 SHALL, when FlushD=0 and StallD=1, hold InstrD, PCD, PCPlus4D, ValidD unchanged.
REQ-023 SHALL present an instruction at decode exactly one cycle after its address appears on PCF (latency 1).
REQ-024 SHALL drive PCF, InstrD, PCD, PCPlus4D, ValidD directly from registers (no combinational path from inputs).
REQ-025 SHALL not perform any check or gating on InstrF content; illegal encodings pass through with ValidD=1.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, set PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, overriding all other inputs.
REQ-027 SHALL, in the first edge after reset deasserts (no stall/flush/redirect), set PCF=RESET_PC+4 and InstrD=InstrF fetched at RESET_PC with ValidD=1.
REQ-028 SHALL, if reset asserts mid-stall or mid-redirect, discard the pending state; no held value survives reset.

Verification
REQ-029 Sequential fetch: reset, then 4 free cycles with InstrF=mem[PCF] -> PCF 0,4,8,12,16; InstrD/PCD track one cycle behind; ValidD=1 from cycle 2.
REQ-030 Redirect vs stall: PCF=0x20, StallF=1, StallD=1, PCSrcE=1, PCTargetE=0x0000_0103 -> next PCF=0x0000_0100; IF/ID held.
REQ-031 Flush vs stall: FlushD=1, StallD=1 -> InstrD=0x0000_0013, PCD=0, ValidD=0; next cycle with FlushD=0, StallD=0 loads current InstrF, ValidD=1.
REQ-032 Load-use stall: StallF=StallD=1 for 2 cycles at PCF=0x40 -> PCF stays 0x40, InstrD/PCD (0x3C) unchanged; resumes 0x44 after release.
REQ-033 Wrap: redirect to 0xFFFF_FFFC, free run -> PCF=0x0000_0000 next, PCPlus4D for that fetch = 0x0000_0000.
REQ-034 Reset mid-operation: assert reset during stall with PCF=0x80 -> PCF=RESET_PC, ValidD=0, InstrD=0x0000_0013 next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch stage; owns the PC register and the IF/ID pipeline register.
// Latency: 1 cycle from an address on PCF to its instruction on InstrD.
// Backpressure: StallF holds PCF and StallD holds IF/ID. A redirect (PCSrcE) overrides StallF. A flush (FlushD) overrides StallD.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   StallF, StallD        hold the PC / hold the IF/ID register
//   FlushD                load a bubble into IF/ID
//   PCSrcE, PCTargetE     redirect from execute (target word-aligned here)
//   InstrF                instruction memory read data for PCF (same cycle)
//   PCF                   fetch address to instruction memory
//   InstrD, PCD, PCPlus4D IF/ID register contents presented to decode
//   ValidD                InstrD is a fetched instruction (0 = bubble)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        pc_load;

  // 32-bit add wraps naturally: 0xFFFF_FFFC + 4 = 0.
  assign pc_plus4_f = PCF + 32'd4;

  // Redirect targets are forced to word alignment by masking the low two bits.
  assign pc_next = PCSrcE ? (PCTargetE & ~32'h0000_0003) : pc_plus4_f;

  // A redirect must never be lost, so it wins over a fetch stall.
  assign pc_load = ~StallF | PCSrcE;

  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (pc_load) begin
      PCF <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed scoreboard bench for fetch_stage.
// Latency: each expectation is checked on the falling edge after the rising edge it targets.
// Backpressure: exercises stall, flush, redirect, wrap and reset-mid-stall sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  logic        ovr_en;
  logic [31:0] ovr_val;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int step_no = 0;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4d;
    logic        v;
  } exp_t;

  exp_t sb[$];

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory contents: a distinct, address-derived word per location.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign InstrF = ovr_en ? ovr_val : imem(PCF);

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step%0d: got %h expected %h", nm, id, act, req);
    end
  endtask

  // Monitor: compares every expectation that has come due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("PCF",      e.id, PCF,      e.pcf);
      chk("InstrD",   e.id, InstrD,   e.instr);
      chk("PCD",      e.id, PCD,      e.pcd);
      chk("PCPlus4D", e.id, PCPlus4D, e.p4d);
      chk("ValidD",   e.id, {31'd0, ValidD}, {31'd0, e.v});
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                      input logic ps, input logic [31:0] tgt,
                      input logic [31:0] e_pcf, input logic [31:0] e_instr,
                      input logic [31:0] e_pcd, input logic [31:0] e_p4d, input logic e_v);
    exp_t e;
    reset = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    step_no++;
    e.due = cyc + 1; e.id = step_no;
    e.pcf = e_pcf; e.instr = e_instr; e.pcd = e_pcd; e.p4d = e_p4d; e.v = e_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    ovr_en = 1'b0; ovr_val = 32'h0;
    //    rst sf sd fd ps target         PCF            InstrD                PCD            PCPlus4D       V
    // Reset state
    step(1, 0, 0, 0, 0, 32'h0,          32'h0,         NOP,                  32'h0,         32'h0,         0);
    // Sequential fetch
    step(0, 0, 0, 0, 0, 32'h0,          32'h4,         imem(32'h0),          32'h0,         32'h4,         1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h8,         imem(32'h4),          32'h4,         32'h8,         1);
    step(0, 0, 0, 0, 0, 32'h0,          32'hC,         imem(32'h8),          32'h8,         32'hC,         1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h10,        imem(32'hC),          32'hC,         32'h10,        1);
    // Redirect with misaligned target 0x22 -> 0x20
    step(0, 0, 0, 0, 1, 32'h22,         32'h20,        imem(32'h10),         32'h10,        32'h14,        1);
    // Redirect beats StallF; IF/ID held by StallD
    step(0, 1, 1, 0, 1, 32'h103,        32'h100,       imem(32'h10),         32'h10,        32'h14,        1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h104,       imem(32'h100),        32'h100,       32'h104,       1);
    // Flush beats StallD
    step(0, 0, 1, 1, 0, 32'h0,          32'h108,       NOP,                  32'h0,         32'h0,         0);
    // Illegal encoding passes through untouched
    ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFF;
    step(0, 0, 0, 0, 0, 32'h0,          32'h10C,       32'hFFFF_FFFF,        32'h108,       32'h10C,       1);
    ovr_en = 1'b0;
    // StallF alone: PC holds, IF/ID keeps loading
    step(0, 1, 0, 0, 0, 32'h0,          32'h10C,       imem(32'h10C),        32'h10C,       32'h110,       1);
    // Load-use stall at 0x40
    step(0, 0, 0, 0, 1, 32'h3C,         32'h3C,        imem(32'h10C),        32'h10C,       32'h110,       1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h40,        imem(32'h3C),         32'h3C,        32'h40,        1);
    step(0, 1, 1, 0, 0, 32'h0,          32'h40,        imem(32'h3C),         32'h3C,        32'h40,        1);
    step(0, 1, 1, 0, 0, 32'h0,          32'h40,        imem(32'h3C),         32'h3C,        32'h40,        1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h44,        imem(32'h40),         32'h40,        32'h44,        1);
    // Wrap at top of address space
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, imem(32'h44),         32'h44,        32'h48,        1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h0,         imem(32'hFFFF_FFFC),  32'hFFFF_FFFC, 32'h0,         1);
    step(0, 0, 0, 0, 0, 32'h0,          32'h4,         imem(32'h0),          32'h0,         32'h4,         1);
    // Reset in the middle of a stall with a pending redirect
    step(0, 0, 0, 0, 1, 32'h80,         32'h80,        imem(32'h4),          32'h4,         32'h8,         1);
    step(0, 1, 1, 0, 0, 32'h0,          32'h80,        imem(32'h4),          32'h4,         32'h8,         1);
    step(1, 1, 1, 0, 1, 32'h200,        32'h0,         NOP,                  32'h0,         32'h0,         0);
    // First edge after reset release
    step(0, 0, 0, 0, 0, 32'h0,          32'h4,         imem(32'h0),          32'h0,         32'h4,         1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
